// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises a bouncing pin, filters it for DEB_CYCLES clocks and
// reports press/release events plus the settled key level.
module key_debounce #(
    parameter int unsigned DEB_CYCLES     = 4000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic flag,
    output logic stable,
    output logic key_release,
    output logic key_level
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFiltDn,
        StHeld,
        StFiltUp
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
        end
    end

    assign pressed = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            flag        <= 1'b0;
            stable      <= 1'b0;
            key_release <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            stable      <= 1'b0;
            key_release <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pressed) begin
                        state_q <= StFiltDn;
                        cnt_q   <= '0;
                        flag    <= 1'b1;
                    end
                end
                StFiltDn: begin
                    if (!pressed) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        flag    <= 1'b0;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StHeld;
                        cnt_q     <= '0;
                        flag      <= 1'b0;
                        stable    <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHeld: begin
                    if (!pressed) begin
                        state_q <= StFiltUp;
                        cnt_q   <= '0;
                        flag    <= 1'b1;
                    end
                end
                StFiltUp: begin
                    // A bounce back to pressed returns to HELD silently.
                    if (pressed) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
                        flag    <= 1'b0;
                    end else if (cnt_q == CntMax) begin
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        flag        <= 1'b0;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    flag      <= 1'b0;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_CYCLES=8: reset, press, bounce, release,
// reset mid-filter and the active-high pin variant.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_in_h;
    logic flag, stable, key_release, key_level;
    logic flag_h, stable_h, key_release_h, key_level_h;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .DEB_CYCLES    (8),
        .SYNC_STAGES   (2),
        .KEY_ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .flag       (flag),
        .stable     (stable),
        .key_release(key_release),
        .key_level  (key_level)
    );

    key_debounce #(
        .DEB_CYCLES    (8),
        .SYNC_STAGES   (2),
        .KEY_ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in_h),
        .flag       (flag_h),
        .stable     (stable_h),
        .key_release(key_release_h),
        .key_level  (key_level_h)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic flag_seen;

    initial begin
        rst      = 1'b1;
        key_in   = 1'b1;
        key_in_h = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) tick();
        check("rst_flag", flag, 1'b0);
        check("rst_stable", stable, 1'b0);
        check("rst_release", key_release, 1'b0);
        check("rst_level", key_level, 1'b0);
        check("rst_hi_all", flag_h | stable_h | key_release_h | key_level_h, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_quiet", flag | stable | key_release | key_level, 1'b0);
        end

        // Clean press: edge 0 is the first tick after the pin goes low
        key_in = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("press_flag", flag, (e >= 2));
            check("press_no_stable", stable, 1'b0);
            check("press_level", key_level, 1'b0);
        end
        tick();
        check("press_stable", stable, 1'b1);
        check("press_flag_low", flag, 1'b0);
        check("press_level_up", key_level, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("held_no_repeat", stable | flag, 1'b0);
            check("held_level", key_level, 1'b1);
        end

        // Clean release
        key_in = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("rel_flag", flag, (e >= 2));
            check("rel_no_pulse", key_release, 1'b0);
            check("rel_level_held", key_level, 1'b1);
        end
        tick();
        check("rel_pulse", key_release, 1'b1);
        check("rel_level_drop", key_level, 1'b0);
        check("rel_flag_low", flag, 1'b0);
        tick();
        check("rel_single", key_release, 1'b0);
        for (int i = 0; i < 10; i++) tick();

        // Bounce: low 5, high 1, low 4, then high
        flag_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            key_in = (i < 5 || (i >= 6 && i < 10)) ? 1'b0 : 1'b1;
            tick();
            if (flag) flag_seen = 1'b1;
            check("bounce_no_stable", stable, 1'b0);
            check("bounce_level", key_level, 1'b0);
        end
        check("bounce_flag_pulsed", flag_seen, 1'b1);
        check("bounce_flag_closed", flag, 1'b0);

        // Reset mid-filter on edge 6 with the key held low
        key_in = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check("midrst_no_stable", stable, 1'b0);
        end
        rst = 1'b1;
        tick();
        check("midrst_cleared", flag | stable | key_release | key_level, 1'b0);
        rst = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("midrst_flag", flag, (e >= 2));
            check("midrst_no_stable_yet", stable, 1'b0);
        end
        tick();
        check("midrst_stable", stable, 1'b1);
        check("midrst_level", key_level, 1'b1);
        key_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("midrst_back_idle", key_level | flag, 1'b0);

        // Active-high variant
        key_in_h = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("hi_flag", flag_h, (e >= 2));
            check("hi_no_stable", stable_h, 1'b0);
        end
        tick();
        check("hi_stable", stable_h, 1'b1);
        check("hi_flag_low", flag_h, 1'b0);
        check("hi_level", key_level_h, 1'b1);
        tick();
        check("hi_single", stable_h, 1'b0);
        check("lo_unaffected", key_level | flag, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
